// File: rtl/pc_unit.sv
// RV32I fetch-stage program counter: next-PC selection (trap > redirect > stall > sequential),
// valid/ready fetch handshake, misaligned-redirect fault state and a saturating fetch counter.
module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     INC       = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus_inc,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_count
);

  // INC is 2 or 4, so the low ALIGN_W target bits must be zero
  localparam int unsigned ALIGN_W = $clog2(INC);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e           state_q;
  logic [XLEN-1:0]  pc_q;
  logic             fetch_valid_q;
  logic             fault_q;
  logic [CNT_W-1:0] fetch_count_q;
  logic             misaligned;

  assign misaligned  = redirect_target[ALIGN_W-1:0] != '0;
  assign pc_plus_inc = pc_q + XLEN'(INC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VEC;
      fetch_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        // one bubble after reset release
        BOOT: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN: begin
          if (trap_valid) begin
            pc_q <= trap_vector;
          end else if (redirect_valid && misaligned) begin
            state_q       <= FAULT;
            fetch_valid_q <= 1'b0;
            fault_q       <= 1'b1;
          end else if (redirect_valid) begin
            pc_q <= redirect_target;
          end else if (!stall && fetch_ready) begin
            // accepted fetch: advance and count, holding at all-ones
            pc_q <= pc_plus_inc;
            if (fetch_count_q != '1) begin
              fetch_count_q <= fetch_count_q + CNT_W'(1);
            end
          end
        end
        FAULT: begin
          if (trap_valid) begin
            pc_q          <= trap_vector;
            state_q       <= RUN;
            fetch_valid_q <= 1'b1;
            fault_q       <= 1'b0;
          end
        end
        default: begin
          state_q       <= BOOT;
          fetch_valid_q <= 1'b0;
          fault_q       <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign fault       = fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: a 32-bit counter instance plus a CNT_W=2 instance
// sharing the same stimulus to observe counter saturation.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        fetch_ready;

  logic        fetch_valid, fault;
  logic [31:0] pc, pc_plus_inc, fetch_count;
  logic        fetch_valid2, fault2;
  logic [31:0] pc2, pc_plus_inc2;
  logic [1:0]  fetch_count2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        flt;
    logic [31:0] cnt;
    logic        c2v;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .INC(4), .RESET_VEC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .pc(pc), .pc_plus_inc(pc_plus_inc), .fault(fault),
    .fetch_count(fetch_count)
  );

  pc_unit #(.XLEN(32), .INC(4), .RESET_VEC(32'h0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid2),
    .pc(pc2), .pc_plus_inc(pc_plus_inc2), .fault(fault2),
    .fetch_count(fetch_count2)
  );

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] p, input logic fv, input logic flt,
                      input logic [31:0] cnt, input logic c2v, input logic [1:0] cnt2);
    exp_t e;
    e.pc = p; e.fv = fv; e.flt = flt; e.cnt = cnt; e.c2v = c2v; e.cnt2 = cnt2;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp({t, ".pc"},    64'(pc),          64'(e.pc));
      cmp({t, ".valid"}, 64'(fetch_valid), 64'(e.fv));
      cmp({t, ".fault"}, 64'(fault),       64'(e.flt));
      cmp({t, ".count"}, 64'(fetch_count), 64'(e.cnt));
      if (e.c2v) cmp({t, ".count2"}, 64'(fetch_count2), 64'(e.cnt2));
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs, then check after the edge.
  task automatic step(input string tag, input logic tv, input logic [31:0] tvec,
                      input logic rv, input logic [31:0] rt, input logic st, input logic rdy,
                      input logic [31:0] ep, input logic efv, input logic eflt,
                      input logic [31:0] ecnt, input logic c2v, input logic [1:0] ecnt2);
    trap_valid = tv; trap_vector = tvec;
    redirect_valid = rv; redirect_target = rt;
    stall = st; fetch_ready = rdy;
    push(tag, ep, efv, eflt, ecnt, c2v, ecnt2);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    trap_valid = 1'b0; trap_vector = '0; fetch_ready = 1'b0;
    #2;
    push("reset", 32'h0, 1'b0, 1'b0, 32'd0, 1'b1, 2'd0);
    pop_check();

    // Sequential fetch from reset
    @(negedge clk);
    rst = 1'b0;
    fetch_ready = 1'b1;
    push("boot", 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0);
    pop_check();
    step("run0", 0, 0, 0, 0, 0, 1, 32'h0,  1, 0, 32'd0, 0, 0);
    step("seq4", 0, 0, 0, 0, 0, 1, 32'h4,  1, 0, 32'd1, 0, 0);
    step("seq8", 0, 0, 0, 0, 0, 1, 32'h8,  1, 0, 32'd2, 0, 0);
    step("seqc", 0, 0, 0, 0, 0, 1, 32'hC,  1, 0, 32'd3, 0, 0);

    // Redirect beats stall and ready, no count
    step("trap100",  1, 32'h100, 0, 0,       0, 0, 32'h100, 1, 0, 32'd3, 0, 0);
    step("redir200", 0, 0,       1, 32'h200, 1, 1, 32'h200, 1, 0, 32'd3, 0, 0);

    // Misaligned redirect faults until a trap
    step("trap100b", 1, 32'h100, 0, 0,       0, 0, 32'h100, 1, 0, 32'd3, 0, 0);
    step("misalign", 0, 0,       1, 32'h202, 0, 1, 32'h100, 0, 1, 32'd3, 0, 0);
    cmp("fault.pc_plus_inc", 64'(pc_plus_inc), 64'h104);
    step("fault_ign", 0, 0,      1, 32'h300, 0, 1, 32'h100, 0, 1, 32'd3, 0, 0);
    step("fault_trap", 1, 32'h80, 0, 0,      0, 1, 32'h80,  1, 0, 32'd3, 0, 0);

    // Wrap past top of address space
    step("trap_top", 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 32'd3, 0, 0);
    cmp("top.pc_plus_inc", 64'(pc_plus_inc), 64'h0);
    step("wrap", 0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 32'd4, 0, 0);

    // Held request, then trap over redirect with ready high
    step("hold0", 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'd4, 0, 0);
    step("hold1", 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'd4, 0, 0);
    step("hold2", 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 32'd4, 0, 0);
    step("trap_over_redir", 1, 32'h40, 1, 32'h500, 0, 1, 32'h40, 1, 0, 32'd4, 0, 0);

    // Asynchronous reset between edges
    #3;
    trap_valid = 1'b0; redirect_valid = 1'b0; fetch_ready = 1'b1;
    rst = 1'b1;
    #1;
    push("async_rst", 32'h0, 1'b0, 1'b0, 32'd0, 1'b1, 2'd0);
    pop_check();
    @(negedge clk);
    rst = 1'b0;
    step("rboot", 0, 0, 0, 0, 0, 1, 32'h0,  1, 0, 32'd0, 1, 2'd0);
    step("sat1",  0, 0, 0, 0, 0, 1, 32'h4,  1, 0, 32'd1, 1, 2'd1);
    step("sat2",  0, 0, 0, 0, 0, 1, 32'h8,  1, 0, 32'd2, 1, 2'd2);
    step("sat3",  0, 0, 0, 0, 0, 1, 32'hC,  1, 0, 32'd3, 1, 2'd3);
    step("sat4",  0, 0, 0, 0, 0, 1, 32'h10, 1, 0, 32'd4, 1, 2'd3);
    step("sat5",  0, 0, 0, 0, 0, 1, 32'h14, 1, 0, 32'd5, 1, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter generator for the RV32I fetch stage. It is the sequential successor of the plus4 adder.
- Holds the PC register and computes PC+INC with modulo wrap.
- Selects the next PC from trap, redirect or sequential sources.
- Drives a valid/ready fetch handshake toward instruction memory, flags misaligned redirect targets, and counts accepted fetches.

Parameters:
- XLEN, 32, PC and target width in bits.
- INC, 4, sequential increment in bytes; must be 2 or 4 and sets the alignment requirement.
- RESET_VEC, 0, PC value loaded on reset.
- CNT_W, 32, width of the accepted-fetch counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC; no sequential advance.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  XLEN  branch/jump target.
- trap_valid  in  1  exception/trap entry this cycle.
- trap_vector  in  XLEN  trap handler address; always treated as aligned.
- fetch_ready  in  1  instruction memory accepts pc this cycle.
- fetch_valid  out  1  pc is a valid fetch request.
- pc  out  XLEN  current fetch address.
- pc_plus_inc  out  XLEN  combinational pc+INC, modulo 2^XLEN.
- fault  out  1  misaligned-redirect fault pending.
- fetch_count  out  CNT_W  number of accepted fetches, saturating.

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc=RESET_VEC, state=BOOT, fetch_valid=0, fault=0, fetch_count=0.
  - Reset overrides every other input.
- States:
  - BOOT: fetch_valid=0, pc holds; the next edge moves to RUN unconditionally. This guarantees exactly one bubble after reset release.
  - RUN: fetch_valid=1 and fault=0.
  - FAULT: fetch_valid=0, fault=1, pc holds the faulting target's predecessor (the pc at the time the fault was detected).
- Next-PC priority per edge in RUN, highest first:
  1. trap_valid: pc←trap_vector, stay RUN.
  2. redirect_valid with redirect_target[log2(INC)-1:0]≠0: pc unchanged, go to FAULT.
  3. redirect_valid aligned: pc←redirect_target.
  4. stall=1: pc unchanged.
  5. fetch_ready=1: pc←pc+INC (wraps to 0 past 2^XLEN−INC).
  6. otherwise: pc unchanged, request held.
- Handshake:
  - A fetch is accepted when fetch_valid and fetch_ready are high, stall=0, and no trap or redirect fires in the same cycle.
  - While fetch_valid=1 and the request is not accepted, pc must not change unless a trap or redirect is taken.
- Redirect/trap vs ready:
  - A trap or redirect in the same cycle as fetch_ready cancels the sequential advance.
  - fetch_count does not increment in that cycle, because the fetched word is discarded.
- Stall vs redirect: a redirect or trap is taken even when stall=1 (flush beats stall).
- FAULT state:
  - Only trap_valid leaves FAULT: pc←trap_vector, fault→0, state→RUN.
  - redirect_valid, stall and fetch_ready are ignored in FAULT.
- fetch_count: increments by 1 per accepted fetch and saturates at 2^CNT_W−1 (no wrap).
- Latency: pc reflects a trap or redirect on the edge where it is sampled; fetch_valid is high the same cycle.

Test Plan:
1. Reset release, fetch_ready=1 for 4 cycles, INC=4, RESET_VEC=0 →
   - cycle0 BOOT: fetch_valid=0, pc=0.
   - Then pc=0,4,8,12 with fetch_valid=1.
   - fetch_count=3 after the third advance.
2. pc=0x00000100, redirect_valid=1, target=0x00000200, with stall=1 and fetch_ready=1 →
   - Next pc=0x200.
   - fetch_count unchanged.
3. redirect target=0x00000202 (INC=4) →
   - fault=1, fetch_valid=0, pc holds 0x100.
   - redirect to 0x300 ignored.
   - Then trap_valid=1, vector=0x80 → pc=0x80, fault=0, fetch_valid=1.
4. Load pc=0xFFFFFFFC via trap, fetch_ready=1 →
   - Next pc=0x00000000.
   - pc_plus_inc=0 while pc=0xFFFFFFFC.
5. fetch_ready=0 for 3 cycles →
   - pc and fetch_valid stable.
   - The same cycle with trap_valid=1 and redirect_valid=1 → pc=trap_vector.
6. Assert rst mid-stream at pc=0x40, asynchronously between edges →
   - pc=RESET_VEC, fetch_valid=0, fetch_count=0 immediately.
   - CNT_W=2 bench: 5 accepted fetches → fetch_count saturates at 3.
